// File: rtl/writeback_stage_hs.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage_hs
// Purpose  : Pipeline writeback stage with load-data alignment, flush handling
//            and discard tracking for in-flight load responses.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage_hs #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ms_valid,
    input  logic              ms_wen,
    input  logic [REG_AW-1:0] ms_regsrc,
    input  logic [DATA_W-1:0] ms_alu_result,
    input  logic              ms_is_load,
    input  logic [2:0]        ms_load_type,
    output logic              ws_allowin,
    input  logic              flush,
    input  logic [DATA_W-1:0] dram_rdata,
    input  logic              dram_data_ok,
    output logic              wb_wen,
    output logic [REG_AW-1:0] wb_regsrc,
    output logic [DATA_W-1:0] wb_regwdata,
    output logic              fwd_busy,
    output logic [REG_AW-1:0] fwd_regsrc
);

    localparam int c_off_w = $clog2(DATA_W / 8);
    localparam int c_word_mask_i = (1 << c_off_w) - 4;
    localparam logic [c_off_w-1:0] c_half_mask = {{(c_off_w-1){1'b1}}, 1'b0};
    localparam logic [c_off_w-1:0] c_word_mask = c_word_mask_i[c_off_w-1:0];

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_wait  = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam logic [2:0] c_lt_lb  = 3'd1;
    localparam logic [2:0] c_lt_lbu = 3'd2;
    localparam logic [2:0] c_lt_lh  = 3'd3;
    localparam logic [2:0] c_lt_lhu = 3'd4;

    logic [1:0]        r_state;
    logic              r_discard;
    logic              r_wen;
    logic [REG_AW-1:0] r_regsrc;
    logic [DATA_W-1:0] r_alu_result;
    logic              r_is_load;
    logic [2:0]        r_load_type;
    logic [DATA_W-1:0] r_load_data;

    logic              w_accept;
    logic              w_done;
    logic [c_off_w-1:0] w_off;
    logic [c_off_w+2:0] w_byte_sel;
    logic [c_off_w+2:0] w_half_sel;
    logic [c_off_w+2:0] w_word_sel;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_word;
    logic [DATA_W-1:0] w_aligned;

    // Offset comes from the latched address: the response arrives cycles later.
    assign w_off      = r_alu_result[c_off_w-1:0];
    assign w_byte_sel = {w_off, 3'b000};
    assign w_half_sel = {w_off & c_half_mask, 3'b000};
    assign w_word_sel = {w_off & c_word_mask, 3'b000};
    assign w_byte     = dram_rdata[w_byte_sel +: 8];
    assign w_half     = dram_rdata[w_half_sel +: 16];
    assign w_word     = dram_rdata[w_word_sel +: 32];

    always_comb begin
        w_aligned = DATA_W'($signed(w_word));
        case (r_load_type)
            c_lt_lb:  w_aligned = DATA_W'($signed(w_byte));
            c_lt_lbu: w_aligned = DATA_W'(w_byte);
            c_lt_lh:  w_aligned = DATA_W'($signed(w_half));
            c_lt_lhu: w_aligned = DATA_W'(w_half);
            default:  w_aligned = DATA_W'($signed(w_word));
        endcase
    end

    assign ws_allowin = !reset && !r_discard &&
                        ((r_state == c_st_empty) || (r_state == c_st_done));
    assign w_accept   = ms_valid && ws_allowin && !flush;
    assign w_done     = !reset && (r_state == c_st_done);

    assign wb_wen      = w_done && r_wen && !flush &&
                         !((ZERO_REG != 0) && (r_regsrc == '0));
    assign wb_regsrc   = w_done ? r_regsrc : '0;
    assign wb_regwdata = w_done ? (r_is_load ? r_load_data : r_alu_result) : '0;
    assign fwd_busy    = !reset && (r_state == c_st_wait);
    assign fwd_regsrc  = (!reset && (r_state != c_st_empty)) ? r_regsrc : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_empty;
            r_discard <= 1'b0;
            r_wen     <= 1'b0;
            r_regsrc  <= '0;
            r_is_load <= 1'b0;
        end else begin
            case (r_state)
                c_st_wait: begin
                    if (flush) begin
                        r_state <= c_st_empty;
                        // A response landing with the flush is consumed here,
                        // so no later orphan response needs to be dropped.
                        if (!dram_data_ok) r_discard <= 1'b1;
                    end else if (dram_data_ok) begin
                        r_load_data <= w_aligned;
                        r_state     <= c_st_done;
                    end
                end
                default: begin
                    if (r_discard && dram_data_ok) r_discard <= 1'b0;
                    if (w_accept) begin
                        r_wen        <= ms_wen;
                        r_regsrc     <= ms_regsrc;
                        r_alu_result <= ms_alu_result;
                        r_is_load    <= ms_is_load;
                        r_load_type  <= ms_load_type;
                        r_state      <= ms_is_load ? c_st_wait : c_st_done;
                    end else begin
                        r_state <= c_st_empty;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
